// File: rtl/sync_down_four_bit.sv
// Johnson (twisted-ring) counter stepping in the shift-left direction from all-ones.
// Any code that is not part of the Johnson ring recovers to RESET_VALUE on the next edge.
module sync_down_four_bit #(
  parameter int                 WIDTH       = 4,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  // A Johnson code has at most one boundary between adjacent bits (no wrap-around).
  function automatic logic is_legal(input logic [WIDTH-1:0] s);
    int unsigned edges;
    edges = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (s[i] != s[i+1]) edges++;
    end
    return (edges <= 1);
  endfunction

  function automatic logic [WIDTH-1:0] johnson_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ~s[WIDTH-1]};
  endfunction

  always_comb begin
    state_d = RESET_VALUE;
    if (is_legal(state_q)) state_d = johnson_step(state_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RESET_VALUE;
    else      state_q <= state_d;
  end

  assign out = state_q;

endmodule

// File: tb/tb_sync_down_four_bit.sv
// Bench for sync_down_four_bit: table-driven reference model, directed sequence checks and random resets.
module tb_sync_down_four_bit;

  logic       clk;
  logic       rst;
  logic [3:0] out;

  int tests;
  int fails;
  bit chk;
  logic [3:0] m;

  logic [3:0] ring [8];
  logic [3:0] lit  [8];

  sync_down_four_bit #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: position in the 8-entry ring, anything off the ring goes to 1111.
  function automatic logic [3:0] model_next(input logic [3:0] s);
    for (int i = 0; i < 8; i++) begin
      if (ring[i] == s) return ring[(i + 1) % 8];
    end
    return 4'b1111;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= 4'b1111;
    else      m <= model_next(m);
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) check("model", out, m);
  end

  task automatic illegal_case(input logic [3:0] code);
    @(negedge clk);
    chk = 0;
    #2;
    force dut.state_q = code;
    m = code;
    #1;
    release dut.state_q;
    #1;
    check("forced_code", out, code);
    @(posedge clk);
    #1;
    check("illegal_recover", out, 4'b1111);
    chk = 1;
    @(posedge clk);
    #1;
    check("after_recover", out, 4'b1110);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    chk   = 0;
    ring  = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0111};
    lit   = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
    rst   = 1'b1;
    #1 rst = 1'b0;
    #1 check("async_powerup", out, 4'b1111);
    repeat (2) begin
      @(posedge clk);
      #1 check("reset_hold", out, 4'b1111);
    end

    // Full cycle: two laps against literal sequence.
    @(negedge clk);
    rst = 1'b1;
    chk = 1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1 check("full_cycle", out, lit[k % 8]);
    end

    // Mid-sequence asynchronous reset from 0001.
    for (int k = 0; k < 5; k++) @(posedge clk);
    #1 check("reach_0001", out, 4'b0001);
    #2 rst = 1'b0;
    #1 check("mid_async", out, 4'b1111);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1 check("held_reset", out, 4'b1111);
    end

    // Restart: first edge after release advances.
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 check("restart", out, lit[k]);
    end

    illegal_case(4'b0101);
    illegal_case(4'b1010);
    illegal_case(4'b1101);

    // Coincident reset and clock edge while at 1000.
    @(negedge clk);
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) @(posedge clk);
    #1 check("reach_1000", out, 4'b1000);
    @(posedge clk);
    rst = 1'b0;
    #1 check("coincide", out, 4'b1111);
    @(negedge clk);
    rst = 1'b1;

    // Random reset pulses, some during clock-high, checked by the model each cycle.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          @(posedge clk);
          #($urandom_range(1, 4));
        end else begin
          #($urandom_range(1, 4));
        end
        rst = 1'b0;
        #0.5 check("rand_async", out, 4'b1111);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
      end
    end

    @(negedge clk);
    chk = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
